prng_roll_ctrl: RTL and testbench
=================================

Name: prng_roll_ctrl

Overview:
- Downstream consumer of the PRNG byte stream. Turns a button press into a bounded random result ("dice roll") in 1..N.
- Debounces a raw push-button, runs a short rolling animation of intermediate values, then rejection-samples the final value and holds it.
- The held value feeds the 7-segment decoders.
- Sits between the LFSR/mux output byte and the display logic.

Parameters:
- DEBOUNCE_CYCLES, 16'd50000, number of consecutive stable synchronized samples required before the debounced button level changes. Legal range 2..65535.
- ROLL_STEPS, 4'd8, number of accepted samples per roll; the last one is the result. Legal range 1..15.

Ports:
- CLK  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- rnd_in  input  8  random byte from the PRNG mux
- rnd_valid  input  1  one-cycle strobe; rnd_in is a fresh byte this cycle
- btn  input  1  raw, asynchronous, bouncy roll button; active-high
- range_in  input  4  number of faces N; 0 means 16
- value  output  5  displayed/held value, 0 or 1..16
- value_valid  output  1  one-cycle pulse when the final result is registered
- busy  output  1  high while rolling
- roll_count  output  8  number of completed rolls, wraps 255->0

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, value=0, value_valid=0, busy=0, roll_count=0, synchronizer flops=0, debounced level=0, debounce counter=0, step counter=0, latched range=0.
- btn synchronizer: 2-flop synchronizer feeds the debouncer.
- Debounce counter:
  - Clears whenever the synced level equals the debounced level.
  - Otherwise increments.
  - When it reaches DEBOUNCE_CYCLES-1 while still different, the debounced level takes the synced level at the next edge and the counter clears.
- Press pulse: registered, one cycle. Fires on the cycle after the debounced level rises 0->1. A falling edge produces no event.
- FSM states: IDLE, ROLL.
- IDLE:
  - busy=0; value holds.
  - On press: latch N (range_in, 0->16), load step counter=ROLL_STEPS, go to ROLL.
  - busy=1 from the next edge.
- ROLL, on a cycle with rnd_valid=1:
  - Candidate c = rnd_in[3:0].
  - Accept iff c < N (5-bit compare). On accept: value <= c+1, step counter decrements.
  - Reject: no change to value or step counter.
  - rnd_valid=0 cycles: no change.
- Final accepted sample (step counter==1 at accept):
  - At the same edge: value <= c+1, value_valid <= 1 for exactly one cycle, roll_count increments (mod 256), state <= IDLE, busy <= 0.
- Latency: value updates at the edge following the rnd_valid cycle; no additional pipeline.
- Press during ROLL: ignored. N is not re-latched; range_in changes during ROLL have no effect.
- Press and final accept in the same cycle: the press is dropped. The FSM returns to IDLE, and a new roll needs a new press.
- Rejection has no timeout. With N=16 every sample is accepted; with N=1 only c=0 is accepted.
- Reset asserted mid-roll: immediate return to the reset values above. The button must be released and pressed again after reset.
- value_valid is never asserted outside the final-accept edge. busy never overlaps IDLE.
- All arithmetic is unsigned. Step counter is 4 bits. The c+1 result is 5 bits (max 16).

Test Plan:
- Reset/idle: hold rst=0, drive btn=1 and rnd_valid pulses -> value=0, busy=0, value_valid=0, roll_count=0 throughout. Release rst with btn=0 -> all outputs stay 0.
- Debounce (DEBOUNCE_CYCLES=4):
  - Toggle btn every 2 cycles for 20 cycles -> no press, busy stays 0.
  - Then hold btn=1 -> busy rises exactly 2 (sync) + 4 (debounce) + 1 (press) + 1 cycles after the steady edge.
- Basic roll (ROLL_STEPS=3, range_in=6): press, then rnd_valid with rnd_in=0x02, 0x0F, 0x15, 0x34:
  - value goes 3, (0x0F rejected, unchanged), 6.
  - With 0x34: value=5 (c=4), value_valid pulse on that edge, busy=0, roll_count=1.
- Range edge cases:
  - range_in=0, rnd_in=0xFF -> value=16, accepted.
  - range_in=1, rnd_in=0x01 rejected, then rnd_in=0x10 -> value=1.
- Ignored inputs in ROLL: second press and range_in change mid-roll -> roll completes with the original N. roll_count increments by exactly 1, one value_valid pulse.
- Reset mid-roll: after 1 accepted sample assert rst for 1 cycle -> value=0, busy=0 immediately. Subsequent rnd_valid pulses cause no change until a new press.

Source files
------------

// File: rtl/prng_roll_ctrl.sv
// Dice-roll controller: debounces a button, animates a roll from the
// PRNG byte stream, then rejection-samples and holds a value in 1..N.
module prng_roll_ctrl #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [3:0]  ROLL_STEPS      = 4'd8
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic [7:0] rnd_in,
  input  logic       rnd_valid,
  input  logic       btn,
  input  logic [3:0] range_in,
  output logic [4:0] value,
  output logic       value_valid,
  output logic       busy,
  output logic [7:0] roll_count
);

  typedef enum logic {IDLE, ROLL} state_t;

  state_t      state;
  logic        sync0;
  logic        sync1;
  logic        deb;
  logic        deb_q;
  logic        press;
  logic [15:0] cnt;
  logic [3:0]  steps;
  logic [4:0]  n_lat;
  logic [4:0]  cand;
  logic        accept;

  assign cand   = {1'b0, rnd_in[3:0]};
  assign accept = rnd_valid && (cand < n_lat);

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      sync0 <= 1'b0;
      sync1 <= 1'b0;
      deb   <= 1'b0;
      deb_q <= 1'b0;
      press <= 1'b0;
      cnt   <= 16'd0;
    end else begin
      sync0 <= btn;
      sync1 <= sync0;
      deb_q <= deb;
      press <= deb & ~deb_q;
      if (sync1 == deb) begin
        cnt <= 16'd0;
      end else if (cnt == DEBOUNCE_CYCLES - 16'd1) begin
        deb <= sync1;
        cnt <= 16'd0;
      end else begin
        cnt <= cnt + 16'd1;
      end
    end
  end

  // A press that coincides with the final accept is lost by design.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      value       <= 5'd0;
      value_valid <= 1'b0;
      busy        <= 1'b0;
      roll_count  <= 8'd0;
      steps       <= 4'd0;
      n_lat       <= 5'd0;
    end else begin
      value_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (press) begin
            n_lat <= (range_in == 4'd0) ? 5'd16
                                        : {1'b0, range_in};
            steps <= ROLL_STEPS;
            busy  <= 1'b1;
            state <= ROLL;
          end
        end
        ROLL: begin
          if (accept) begin
            value <= cand + 5'd1;
            steps <= steps - 4'd1;
            if (steps == 4'd1) begin
              value_valid <= 1'b1;
              roll_count  <= roll_count + 8'd1;
              busy        <= 1'b0;
              state       <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prng_roll_ctrl.sv
// Directed bench for prng_roll_ctrl with hand-computed expectations.
// Debounce of 4 samples and 3 roll steps keep runs short.
module tb_prng_roll_ctrl;

  logic       CLK = 1'b0;
  logic       rst;
  logic [7:0] rnd_in;
  logic       rnd_valid;
  logic       btn;
  logic [3:0] range_in;
  logic [4:0] value;
  logic       value_valid;
  logic       busy;
  logic [7:0] roll_count;

  int nvec = 0;
  int nerr = 0;
  int vv_cnt = 0;

  prng_roll_ctrl #(
    .DEBOUNCE_CYCLES(16'd4),
    .ROLL_STEPS(4'd3)
  ) dut (
    .CLK(CLK),
    .rst(rst),
    .rnd_in(rnd_in),
    .rnd_valid(rnd_valid),
    .btn(btn),
    .range_in(range_in),
    .value(value),
    .value_valid(value_valid),
    .busy(busy),
    .roll_count(roll_count)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) if (value_valid) vv_cnt++;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic rnd(input logic [7:0] b);
    rnd_in    = b;
    rnd_valid = 1'b1;
    tick();
    rnd_valid = 1'b0;
  endtask

  task automatic do_press(input logic [3:0] n);
    int k;
    btn = 1'b0;
    tick(8);
    range_in = n;
    btn = 1'b1;
    k = 0;
    while (!busy && k < 20) begin
      tick();
      k++;
    end
    check("press_busy", busy, 1);
    btn = 1'b0;
  endtask

  initial begin
    int c0;
    rst = 1'b0;
    rnd_in = 8'h00;
    rnd_valid = 1'b0;
    btn = 1'b1;
    range_in = 4'd6;
    for (int i = 0; i < 6; i++) begin
      rnd(8'h11);
    end
    check("rst_value", value, 0);
    check("rst_busy", busy, 0);
    check("rst_vv", vv_cnt, 0);
    check("rst_count", roll_count, 0);
    btn = 1'b0;
    rst = 1'b1;
    tick(10);
    check("idle_value", value, 0);
    check("idle_busy", busy, 0);

    // bouncing button never settles long enough
    for (int i = 0; i < 10; i++) begin
      btn = ~btn;
      tick(2);
    end
    btn = 1'b0;
    tick(10);
    check("bounce_busy", busy, 0);
    check("bounce_vv", vv_cnt, 0);

    // steady press: busy rises exactly 8 edges later
    range_in = 4'd6;
    btn = 1'b1;
    tick(7);
    check("lat_busy7", busy, 0);
    tick();
    check("lat_busy8", busy, 1);
    btn = 1'b0;

    rnd(8'h02);
    check("roll_v3", value, 3);
    rnd(8'h0F);
    check("roll_rej", value, 3);
    rnd(8'h15);
    check("roll_v6", value, 6);
    check("roll_vv0", value_valid, 0);
    rnd(8'h34);
    check("roll_v5", value, 5);
    check("roll_vv1", value_valid, 1);
    check("roll_busy", busy, 0);
    check("roll_cnt", roll_count, 1);
    tick();
    check("roll_vv_end", value_valid, 0);

    // N=16 accepts everything
    do_press(4'd0);
    rnd(8'hFF);
    check("n16_v", value, 16);
    rnd(8'hFF);
    rnd(8'hFF);
    check("n16_vv", value_valid, 1);
    check("n16_cnt", roll_count, 2);

    // N=1 accepts only c=0
    do_press(4'd1);
    rnd(8'h01);
    check("n1_rej", value, 16);
    rnd(8'h10);
    check("n1_v", value, 1);
    rnd(8'h20);
    rnd(8'h00);
    check("n1_cnt", roll_count, 3);
    check("n1_busy", busy, 0);

    // second press and range change mid-roll are ignored
    do_press(4'd2);
    c0 = vv_cnt;
    rnd(8'h01);
    check("ign_v2", value, 2);
    range_in = 4'd15;
    btn = 1'b1;
    tick(12);
    btn = 1'b0;
    check("ign_busy", busy, 1);
    rnd(8'h05);
    check("ign_rej", value, 2);
    rnd(8'h00);
    check("ign_v1", value, 1);
    rnd(8'h11);
    check("ign_v2b", value, 2);
    check("ign_cnt", roll_count, 4);
    tick(20);
    check("ign_pulses", vv_cnt - c0, 1);
    check("ign_idle", busy, 0);

    // asynchronous reset mid-roll
    do_press(4'd6);
    rnd(8'h03);
    check("mid_v4", value, 4);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_v", value, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_cnt", roll_count, 0);
    tick();
    rst = 1'b1;
    c0 = vv_cnt;
    for (int i = 0; i < 4; i++) begin
      rnd(8'h01);
    end
    check("post_v", value, 0);
    check("post_busy", busy, 0);
    check("post_vv", vv_cnt - c0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
